uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_tx transmitter between N_REQ byte producers. It grants one requester at a time and drives the transmitter's cts/txdata inputs with a single-cycle launch. It then holds off further launches for a fixed frame time, so a byte is never offered while the transmitter is busy. It sits between the producers (status reporters, debug print, command responder) and uart_tx.

Parameters:
N_REQ, 4, number of requesters (2..8)
BIT_CLK, 87, clocks per UART bit; must match the uart_tx instance
FRAME_CLK, 10*BIT_CLK+4, clocks held in WAIT after a launch; must cover start+8 data+stop+CLEAN/IDLE re-entry; range 1..65535
HOLD_CLK, 2, clocks held after reset before the first launch is allowed

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  1 = new grants allowed; 0 = finish the frame in flight, then stay in IDLE
req_valid  in  N_REQ  per-requester byte-pending flag; held until the matching req_ready pulse
req_data  in  8*N_REQ  byte for requester i on bits [8i+7:8i]; stable while req_valid is high
req_ready  out  N_REQ  one-cycle accept pulse; one-hot or zero
cts  out  1  launch strobe to uart_tx cts; one cycle wide
txdata  out  8  byte to uart_tx txdata; valid whenever cts=1 and held until the next launch
busy  out  1  1 when state != IDLE
grant_id  out  clog2(N_REQ)  index of the last granted requester

Behaviour:
- All state and outputs are registered and updated on posedge clk. reset is sampled only at the clock edge.
- Reset values (reset=0): state=HOLD, count=0, rr_ptr=0, req_ready=0, cts=0, txdata=0, grant_id=0, busy=1.
- Reset asserted mid-frame aborts the schedule immediately. Requesters whose grant was lost must keep req_valid high.
- States:
  - HOLD: count increments each cycle. When count==HOLD_CLK-1, set count=0 and go to IDLE. This covers uart_tx's CLEAN->IDLE start-up.
  - IDLE: if enable=1 and any req_valid=1, pick winner w by round-robin. The search starts at rr_ptr and ascends with wrap. On that edge:
    - txdata <= req_data[w], cts <= 1, req_ready[w] <= 1, grant_id <= w
    - rr_ptr <= (w+1) mod N_REQ, count <= 0, state <= WAIT
  - IDLE with no eligible request: outputs hold, rr_ptr unchanged.
  - WAIT: cts and req_ready return to 0 on the first WAIT edge, so each pulse is exactly one cycle. count increments. When count==FRAME_CLK-1, go to IDLE.
- Latency: request at edge k (state IDLE) -> cts/req_ready high during cycle k+1. Next launch earliest at edge k+FRAME_CLK+1.
- The requester sees req_ready while its req_valid is still high. That cycle does not cause a re-grant, because the state is WAIT. The requester may present a new byte or drop valid in the following cycle.
- Simultaneous requests: only one grant per launch. The loser keeps valid and is served next if still asserted, because rr_ptr has moved past the winner.
- rr_ptr wrap: from N_REQ-1 to 0.
- enable deasserted during WAIT: the frame completes normally, then the block stays in IDLE.
- req_valid dropping without ready: the request is withdrawn and no error is raised.
- count is 16 bits wide, shared by HOLD and WAIT, and never exceeds max(HOLD_CLK, FRAME_CLK)-1.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings HOLD=0, IDLE=1, WAIT=2
  - UART_BIT_CLK default 87
  - function frame_clk(bit_clk) = 10*bit_clk+4
  - COUNT_W=16
- One sub-module rr_pick: combinational round-robin select. Inputs are req vector and rr_ptr; outputs are winner index and any_req. It is reusable by later shared-resource controllers.

Test Plan:
All scenarios use N_REQ=4, BIT_CLK=4, FRAME_CLK=44, HOLD_CLK=2.
- Reset then req_valid=4'b0001, data0=8'hA5 from cycle 0 -> no cts before HOLD ends; cts=1 for exactly 1 cycle with txdata=A5, req_ready=0001, grant_id=0; uart_tx model outputs 0,1,0,1,0,0,1,0,1 then stop.
- req_valid=4'b1111 continuously, data i=8'h10+i -> grant order 0,1,2,3,0; consecutive cts pulses exactly 45 cycles apart; each req_ready one-hot.
- rr_ptr=3 state (after granting 2), then req_valid=4'b0101 -> requester 0 wins (wrap), then 2.
- enable=0 with req_valid=4'b0010 -> no cts for 200 cycles, busy=0; then enable=1 -> cts next cycle+1 with data1. Also drop enable during WAIT -> that frame's busy lasts full 44 WAIT cycles, no new grant.
- Assert reset 20 cycles into WAIT -> next edge: cts=0, req_ready=0, busy=1, grant_id=0; after HOLD, pending requester 0 is granted first (rr_ptr reset).
- req_valid pulse withdrawn before IDLE returns -> no grant, no cts, state stays IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART scheduling definitions: FSM encodings, timing defaults, counter width.
package uart_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int UART_BIT_CLK = 87;
    localparam int COUNT_W      = 16;

    // Frame time: start + 8 data + stop bits, plus a few clocks for uart_tx to re-enter IDLE.
    function automatic int frame_clk(input int bit_clk);
        return 10 * bit_clk + 4;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first asserted req at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    int idx;

    // Scan N slots starting at ptr; the first hit wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers.
// One-cycle launch (cts/req_ready), then a fixed frame hold-off before the next grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int BIT_CLK   = UART_BIT_CLK,
    parameter int FRAME_CLK = frame_clk(BIT_CLK),
    parameter int HOLD_CLK  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       cts,
    output logic [7:0]                 txdata,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [COUNT_W-1:0] HOLD_LAST  = COUNT_W'(HOLD_CLK - 1);
    localparam logic [COUNT_W-1:0] FRAME_LAST = COUNT_W'(FRAME_CLK - 1);

    state_t               state, state_d;
    logic [COUNT_W-1:0]   count, count_d;
    logic [IW-1:0]        rr_ptr, rr_ptr_d;
    logic [IW-1:0]        win;
    logic                 any_req;
    logic                 launch;
    logic [7:0]           sel_byte;
    logic [N_REQ-1:0]     ready_d;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .winner  (win),
        .any_req (any_req)
    );

    // Winner's byte and one-hot accept vector.
    always_comb begin
        sel_byte = '0;
        ready_d  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IW'(i)) begin
                sel_byte   = req_data[8*i +: 8];
                ready_d[i] = launch;
            end
        end
    end

    // Next-state: HOLD start-up delay, IDLE grant decision, WAIT frame hold-off.
    always_comb begin
        state_d  = state;
        count_d  = count;
        rr_ptr_d = rr_ptr;
        launch   = 1'b0;
        case (state)
            HOLD: begin
                if (count == HOLD_LAST) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = count + 1'b1;
                end
            end
            IDLE: begin
                if (enable && any_req) begin
                    launch   = 1'b1;
                    count_d  = '0;
                    state_d  = WAIT;
                    rr_ptr_d = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
                end
            end
            WAIT: begin
                if (count == FRAME_LAST) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = count + 1'b1;
                end
            end
            default: begin
                count_d = '0;
                state_d = HOLD;
            end
        endcase
    end

    // State and registered outputs; cts/req_ready are high only on the launch edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= HOLD;
            count     <= '0;
            rr_ptr    <= '0;
            req_ready <= '0;
            cts       <= 1'b0;
            txdata    <= '0;
            grant_id  <= '0;
            busy      <= 1'b1;
        end else begin
            state     <= state_d;
            count     <= count_d;
            rr_ptr    <= rr_ptr_d;
            cts       <= launch;
            req_ready <= ready_d;
            busy      <= (state_d != IDLE);
            if (launch) begin
                txdata   <= sel_byte;
                grant_id <= win;
            end
        end
    end

endmodule
